fetch_stage: RTL and testbench

//   Instruction fetch stage: owns the PC, drives the imem address, and produces the
//   {pc, instruction, enable} triple consumed by the F/D pipeline latch.

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_stage_pc_next_sel.sv | 21 ++
 rtl/fetch_stage_register.sv | 26 ++
 rtl/fetch_stage.sv | 116 +++++++++++
 tb/tb_fetch_stage.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM state encodings, default bubble word,
// flush counter width and a saturating increment helper.
package fetch_stage_pkg;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_NOP = 32'd0;
   localparam int          FLUSH_CNT_W = 4;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/fetch_stage_pc_next_sel.sv
// Next-PC priority mux: redirect target, then stall hold, then state hold
// (BOOT/FLUSH), otherwise sequential PC+1.
module pc_next_sel (
   input  logic [31:0] i_pc,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_stall,
   input  logic        i_hold,
   output logic [31:0] o_pc_next
);

   always_comb begin
      o_pc_next = i_pc + 32'd1;
      if (i_redirect_valid) begin
         o_pc_next = i_redirect_pc;
      end else if (i_stall || i_hold) begin
         o_pc_next = i_pc;
      end
   end

endmodule

// File: rtl/fetch_stage_register.sv
// Generic enabled register with asynchronous active-high reset to a
// parameterised value; holds the fetch PC.
module register #(
   parameter int           W       = 32,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         i_en,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_q <= RST_VAL;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC ownership, imem addressing, stall/redirect handling
// and NOP bubble injection. Define FETCH_PERF_CNT_EN to add stall/flush counters.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'd0,
   parameter int          ADDR_W      = 12,
   parameter int          FLUSH_DEPTH = 1,
   parameter logic [31:0] NOP_INST    = DEFAULT_NOP
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall_in,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic [ADDR_W-1:0] address_imem,
   input  logic [31:0]       q_imem,
   output logic [31:0]       pc_out,
   output logic [31:0]       inst_out,
   output logic              fd_en
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_DEPTH);

   fetch_state_t            r_state;
   logic [FLUSH_CNT_W-1:0]  r_flush_left;
   logic [31:0]             w_pc;
   logic [31:0]             w_pc_next;
   logic                    w_hold;
   logic                    w_bubble;

   // PC only advances in RUN; BOOT and FLUSH sit on the current/target address.
   assign w_hold = (r_state != ST_RUN);

   pc_next_sel u_pc_next_sel (
      .i_pc             (w_pc),
      .i_redirect_valid (redirect_valid),
      .i_redirect_pc    (redirect_pc),
      .i_stall          (stall_in),
      .i_hold           (w_hold),
      .o_pc_next        (w_pc_next)
   );

   register #(
      .W       (32),
      .RST_VAL (RESET_PC)
   ) u_pc_reg (
      .clock (clock),
      .reset (reset),
      .i_en  (1'b1),
      .i_d   (w_pc_next),
      .o_q   (w_pc)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= ST_BOOT;
         r_flush_left <= '0;
      end else if (redirect_valid) begin
         r_state      <= (FLUSH_DEPTH == 0) ? ST_RUN : ST_FLUSH;
         r_flush_left <= FLUSH_LOAD;
      end else if (!stall_in) begin
         case (r_state)
            ST_BOOT: r_state <= ST_RUN;
            ST_FLUSH: begin
               if (r_flush_left <= FLUSH_CNT_W'(1)) begin
                  r_state      <= ST_RUN;
                  r_flush_left <= '0;
               end else begin
                  r_flush_left <= r_flush_left - FLUSH_CNT_W'(1);
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   // Address depends on the PC register alone, never on stall/redirect inputs.
   assign address_imem = w_pc[ADDR_W-1:0];
   assign pc_out       = w_pc + 32'd1;
   assign w_bubble     = redirect_valid | w_hold;
   assign inst_out     = w_bubble ? NOP_INST : q_imem;
   assign fd_en        = reset | ~stall_in | redirect_valid;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;
   logic        w_flush_bubble;

   // Bubbles that reach the latch: the redirect cycle itself or an unstalled FLUSH cycle.
   assign w_flush_bubble = redirect_valid | ((r_state == ST_FLUSH) & ~stall_in);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (stall_in && !redirect_valid) begin
            r_stall_cnt <= sat_inc32(r_stall_cnt);
         end
         if (w_flush_bubble) begin
            r_flush_cnt <= sat_inc32(r_flush_cnt);
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fetch_stage;

   typedef struct {
      logic [11:0] addr;
      logic [31:0] pc_out;
      logic [31:0] inst;
      logic        fd;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        stall_in;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [11:0] address_imem;
   logic [31:0] q_imem;
   logic [31:0] pc_out;
   logic [31:0] inst_out;
   logic        fd_en;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   logic mon_en = 1'b0;

   localparam logic [31:0] NOP = 32'd0;

   // imem model: imem[n] = n + 0x100
   assign q_imem = 32'h100 + {20'd0, address_imem};

   fetch_stage #(
      .RESET_PC    (32'd0),
      .ADDR_W      (12),
      .FLUSH_DEPTH (1),
      .NOP_INST    (32'd0)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .stall_in       (stall_in),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .address_imem   (address_imem),
      .q_imem         (q_imem),
      .pc_out         (pc_out),
      .inst_out       (inst_out),
      .fd_en          (fd_en)
`ifdef FETCH_PERF_CNT_EN
      ,
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic st, input logic rv, input logic [31:0] rpc,
                      input logic [11:0] ea, input logic [31:0] epc,
                      input logic [31:0] ei, input logic efd);
      exp_t e;
      stall_in       = st;
      redirect_valid = rv;
      redirect_pc    = rpc;
      e.addr   = ea;
      e.pc_out = epc;
      e.inst   = ei;
      e.fd     = efd;
      exp_q.push_back(e);
      @(posedge clock);
      #1;
   endtask

   // Monitor: one transaction line per cycle while enabled.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (mon_en) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL underrun: DUT output with no expectation at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               $display("txn t=%0t addr=0x%03h pc_out=0x%08h inst=0x%08h fd_en=%0b",
                        $time, address_imem, pc_out, inst_out, fd_en);
               check("address_imem", {20'd0, address_imem}, {20'd0, e.addr});
               check("pc_out", pc_out, e.pc_out);
               check("inst_out", inst_out, e.inst);
               check("fd_en", {31'd0, fd_en}, {31'd0, e.fd});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b1;
      stall_in       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      repeat (2) @(posedge clock);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;

      // boot then free run
      cyc(0, 0, 0, 12'h000, 32'h1, NOP, 1);
      cyc(0, 0, 0, 12'h000, 32'h1, 32'h100, 1);
      cyc(0, 0, 0, 12'h001, 32'h2, 32'h101, 1);
      cyc(0, 0, 0, 12'h002, 32'h3, 32'h102, 1);
      cyc(0, 0, 0, 12'h003, 32'h4, 32'h103, 1);
      cyc(0, 0, 0, 12'h004, 32'h5, 32'h104, 1);
      // stall 3 cycles at pc=5
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 12'h005, 32'h6, 32'h105, 0);
`ifdef FETCH_PERF_CNT_EN
      check("stall_cnt_3", stall_cnt, 32'd3);
`endif
      cyc(0, 0, 0, 12'h005, 32'h6, 32'h105, 1);
      cyc(0, 0, 0, 12'h006, 32'h7, 32'h106, 1);
      cyc(0, 0, 0, 12'h007, 32'h8, 32'h107, 1);
      // redirect to 0x20 at pc=8
      cyc(0, 1, 32'h20, 12'h008, 32'h9, NOP, 1);
      cyc(0, 0, 0, 12'h020, 32'h21, NOP, 1);
`ifdef FETCH_PERF_CNT_EN
      check("flush_cnt_2", flush_cnt, 32'd2);
`endif
      cyc(0, 0, 0, 12'h020, 32'h21, 32'h120, 1);
      // redirect + stall together, then re-redirect in FLUSH, then stall in FLUSH
      cyc(1, 1, 32'h10, 12'h021, 32'h22, NOP, 1);
      cyc(0, 1, 32'h30, 12'h010, 32'h11, NOP, 1);
      cyc(1, 0, 0, 12'h030, 32'h31, NOP, 0);
      cyc(0, 0, 0, 12'h030, 32'h31, NOP, 1);
      cyc(0, 0, 0, 12'h030, 32'h31, 32'h130, 1);
      cyc(0, 0, 0, 12'h031, 32'h32, 32'h131, 1);
`ifdef FETCH_PERF_CNT_EN
      check("flush_cnt_5", flush_cnt, 32'd5);
      check("stall_cnt_4", stall_cnt, 32'd4);
`endif
      // address wrap at 0xFFF
      cyc(0, 1, 32'hFFF, 12'h032, 32'h33, NOP, 1);
      cyc(0, 0, 0, 12'hFFF, 32'h1000, NOP, 1);
      cyc(0, 0, 0, 12'hFFF, 32'h1000, 32'h10FF, 1);
      cyc(0, 0, 0, 12'h000, 32'h1001, 32'h100, 1);
`ifdef FETCH_PERF_CNT_EN
      check("flush_cnt_7", flush_cnt, 32'd7);
`endif
      // move to pc=0x40, then assert reset mid-cycle
      cyc(0, 1, 32'h40, 12'h001, 32'h1002, NOP, 1);
      cyc(0, 0, 0, 12'h040, 32'h41, NOP, 1);
      mon_en = 1'b0;
      #1;
      check("pre_rst_addr", {20'd0, address_imem}, 32'h40);
      stall_in = 1'b1;
      reset    = 1'b1;
      #1;
      check("rst_addr", {20'd0, address_imem}, 32'h0);
      check("rst_pc_out", pc_out, 32'h1);
      check("rst_inst", inst_out, NOP);
      check("rst_fd_en", {31'd0, fd_en}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
      check("rst_stall_cnt", stall_cnt, 32'd0);
      check("rst_flush_cnt", flush_cnt, 32'd0);
`endif
      repeat (2) @(posedge clock);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;
      // stalled BOOT persists, then BOOT, then RUN from address 0
      cyc(1, 0, 0, 12'h000, 32'h1, NOP, 0);
      cyc(0, 0, 0, 12'h000, 32'h1, NOP, 1);
      cyc(0, 0, 0, 12'h000, 32'h1, 32'h100, 1);
      cyc(0, 0, 0, 12'h001, 32'h2, 32'h101, 1);
`ifdef FETCH_PERF_CNT_EN
      check("post_rst_stall_cnt", stall_cnt, 32'd1);
      check("post_rst_flush_cnt", flush_cnt, 32'd0);
`endif
      mon_en = 1'b0;
      check("drain", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
